// File: rtl/issue_scheduler.sv
// Age-ordered issue scheduler for a compacting pop-anywhere queue.
// Each cycle it picks up to Lanes of the oldest operand-ready entries and
// pops them into per-lane output registers. These registers drain to the
// execution units over a valid/ready handshake. A watchdog forces in-order
// issue of the head entry once younger entries have bypassed it for too long.
// All state updates on the falling edge of clk_ni.
module issue_scheduler #(
    parameter int  Size    = 16,
    parameter type T       = logic,
    parameter int  Lanes   = 2,
    parameter int  Timeout = 8,
    localparam int Width   = $clog2(Size)
) (
    input  logic              clk_ni,
    input  logic              rst_i,
    input  logic [Width:0]    size_i,
    input  T                  entries_i [Size],
    input  logic [Size-1:0]   ready_i,
    input  logic              flush_i,
    output logic [Size-1:0]   pop_o,
    output logic [Lanes-1:0]  lane_valid_o,
    output T                  lane_data_o [Lanes],
    input  logic [Lanes-1:0]  lane_ready_i,
    output logic              starve_o
);

    localparam int CntW = Width + 1;
    localparam int AgeW = $clog2(Timeout + 1);
    localparam int IdxW = (Size > 1) ? $clog2(Size) : 1;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [AgeW-1:0]   age_reg;
    logic              starve_reg;
    logic [Lanes-1:0]  lane_valid_reg;
    T                  lane_data_reg [Lanes];

    logic [Size-1:0]   entry_valid;
    logic [Size-1:0]   cand;
    logic [Size-1:0]   issue_mask;
    logic [CntW-1:0]   cand_rank [Size];
    logic [CntW-1:0]   num_cand;
    logic [Lanes-1:0]  lane_free;
    logic [Lanes-1:0]  lane_assigned;
    logic [CntW-1:0]   free_rank [Lanes];
    logic [CntW-1:0]   num_free;
    logic [IdxW-1:0]   lane_sel [Lanes];

    // Entry validity and candidacy; in DRAIN only the head may issue.
    for (genvar gi = 0; gi < Size; gi++) begin : g_entry
        assign entry_valid[gi] = (size_i > CntW'(gi));
        assign cand[gi]        = entry_valid[gi] && ready_i[gi] &&
                                 ((state_reg == ST_NORMAL) || (gi == 0));
    end

    // A lane can take a new entry if empty or handing its entry off now.
    for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane_free
        assign lane_free[gi] = !lane_valid_reg[gi] || lane_ready_i[gi];
    end

    // Rank of each candidate among candidates (0 = oldest).
    always_comb begin
        logic [CntW-1:0] cnt_next;
        cnt_next = '0;
        for (int i = 0; i < Size; i++) begin
            cand_rank[i] = cnt_next;
            cnt_next     = cnt_next + CntW'(cand[i]);
        end
        num_cand = cnt_next;
    end

    // Rank of each free lane among free lanes (0 = lowest index).
    always_comb begin
        logic [CntW-1:0] cnt_next;
        cnt_next = '0;
        for (int l = 0; l < Lanes; l++) begin
            free_rank[l] = cnt_next;
            cnt_next     = cnt_next + CntW'(lane_free[l]);
        end
        num_free = cnt_next;
    end

    // The k-th oldest candidate issues iff there are more than k free lanes.
    for (genvar gi = 0; gi < Size; gi++) begin : g_issue
        assign issue_mask[gi] = cand[gi] && (cand_rank[gi] < num_free);
    end

    // Each free lane of rank k receives the candidate of rank k, if any.
    always_comb begin
        for (int l = 0; l < Lanes; l++) begin
            lane_assigned[l] = lane_free[l] && (free_rank[l] < num_cand);
            lane_sel[l]      = '0;
            for (int i = 0; i < Size; i++) begin
                if (cand[i] && (cand_rank[i] == free_rank[l])) begin
                    lane_sel[l] = IdxW'(i);
                end
            end
        end
    end

    // Pop mask: reset suppresses everything, flush empties the queue.
    always_comb begin
        if (rst_i) begin
            pop_o = '0;
        end else if (flush_i) begin
            pop_o = entry_valid;
        end else begin
            pop_o = issue_mask;
        end
    end

    // Lane valid flags: free lanes refill or empty; stalled lanes hold.
    always_ff @(negedge clk_ni) begin
        if (rst_i || flush_i) begin
            lane_valid_reg <= '0;
        end else begin
            for (int l = 0; l < Lanes; l++) begin
                if (lane_free[l]) begin
                    lane_valid_reg[l] <= lane_assigned[l];
                end
            end
        end
    end

    // Lane payload: loaded only when the lane accepts a new entry.
    always_ff @(negedge clk_ni) begin
        for (int l = 0; l < Lanes; l++) begin
            if (!rst_i && !flush_i && lane_assigned[l]) begin
                lane_data_reg[l] <= entries_i[lane_sel[l]];
            end
        end
    end

    // Watchdog age counter and NORMAL/DRAIN state with registered starve flag.
    always_ff @(negedge clk_ni) begin
        if (rst_i || flush_i) begin
            state_reg  <= ST_NORMAL;
            age_reg    <= '0;
            starve_reg <= 1'b0;
        end else begin
            if ((size_i == '0) || pop_o[0]) begin
                age_reg <= '0;
            end else if (age_reg != AgeW'(Timeout)) begin
                age_reg <= age_reg + AgeW'(1);
            end

            case (state_reg)
                ST_NORMAL: begin
                    if ((age_reg == AgeW'(Timeout - 1)) && (size_i != '0) && !pop_o[0]) begin
                        state_reg  <= ST_DRAIN;
                        starve_reg <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pop_o[0]) begin
                        state_reg  <= ST_NORMAL;
                        starve_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= ST_NORMAL;
                    starve_reg <= 1'b0;
                end
            endcase
        end
    end

    assign lane_valid_o = lane_valid_reg;
    assign lane_data_o  = lane_data_reg;
    assign starve_o     = starve_reg;

endmodule

// File: tb/tb_issue_scheduler.sv
// Testbench for issue_scheduler: directed vectors on a 4-entry/2-lane
// instance, plus a randomized scoreboard run on an 8-entry/3-lane instance.
module tb_issue_scheduler;

    typedef logic [7:0] data_t;

    localparam int SizeB    = 8;
    localparam int LanesB   = 3;
    localparam int TimeoutB = 3;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: Size=4, Lanes=2, Timeout=3
    logic [2:0] size_a;
    data_t      entries_a [4];
    logic [3:0] ready_a;
    logic       flush_a;
    logic [3:0] pop_a;
    logic [1:0] lane_valid_a;
    data_t      lane_data_a [2];
    logic [1:0] lane_ready_a;
    logic       starve_a;

    // Instance B: Size=8, Lanes=3, Timeout=3
    logic [3:0] size_b;
    data_t      entries_b [8];
    logic [7:0] ready_b;
    logic       flush_b;
    logic [7:0] pop_b;
    logic [2:0] lane_valid_b;
    data_t      lane_data_b [3];
    logic [2:0] lane_ready_b;
    logic       starve_b;

    issue_scheduler #(
        .Size(4), .T(data_t), .Lanes(2), .Timeout(3)
    ) dut_a (
        .clk_ni(clk), .rst_i(rst), .size_i(size_a), .entries_i(entries_a),
        .ready_i(ready_a), .flush_i(flush_a), .pop_o(pop_a),
        .lane_valid_o(lane_valid_a), .lane_data_o(lane_data_a),
        .lane_ready_i(lane_ready_a), .starve_o(starve_a)
    );

    issue_scheduler #(
        .Size(SizeB), .T(data_t), .Lanes(LanesB), .Timeout(TimeoutB)
    ) dut_b (
        .clk_ni(clk), .rst_i(rst), .size_i(size_b), .entries_i(entries_b),
        .ready_i(ready_b), .flush_i(flush_b), .pop_o(pop_b),
        .lane_valid_o(lane_valid_b), .lane_data_o(lane_data_b),
        .lane_ready_i(lane_ready_b), .starve_o(starve_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // One scheduler cycle on instance A: drive, check pop before the edge,
    // then return just after the falling edge for registered checks.
    task automatic cycle_a(input logic [2:0] sz, input logic [3:0] rdy, input logic [1:0] lrdy,
                           input logic fl, input logic [3:0] exp_pop, input string tag);
        size_a       = sz;
        ready_a      = rdy;
        lane_ready_a = lrdy;
        flush_a      = fl;
        @(posedge clk);
        check_eq({tag, ".pop"}, 32'(pop_a), 32'(exp_pop));
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        flush_a      = 1'b0;
        size_a       = '0;
        ready_a      = '0;
        lane_ready_a = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Fill both lanes, stall them, and let the head age into DRAIN.
    task automatic reach_drain();
        do_reset();
        cycle_a(3'd4, 4'b0011, 2'b00, 1'b0, 4'b0011, "drain_fill");
        for (int c = 1; c <= 3; c++) begin
            cycle_a(3'd4, 4'b0000, 2'b00, 1'b0, 4'b0000, "drain_stall");
            check_eq("drain_stall.starve", 32'(starve_a), 32'(c == 3));
        end
        check_eq("drain.lane_valid", 32'(lane_valid_a), 32'b11);
    endtask

    // Scoreboard state for instance B
    data_t      mq [$];
    data_t      new_q [$];
    logic [2:0] m_valid;
    data_t      m_data [3];
    bit         m_drain;
    int         m_age;
    int         next_id;
    int         transfers;
    bit         seen [256];
    int         free_l [3];
    int         nfree;
    int         fi;
    int         old_age;
    bit         old_drain;
    int         old_size;
    logic [7:0] exp_pop;
    logic [7:0] valid_mask;

    initial begin
        rst          = 1'b1;
        flush_a      = 1'b0;
        size_a       = '0;
        ready_a      = '0;
        lane_ready_a = '0;
        entries_a[0] = 8'hA0;
        entries_a[1] = 8'hB1;
        entries_a[2] = 8'hC2;
        entries_a[3] = 8'hD3;
        flush_b      = 1'b0;
        size_b       = '0;
        ready_b      = '0;
        lane_ready_b = '0;
        for (int i = 0; i < SizeB; i++) entries_b[i] = 8'h00;

        // Reset state
        @(negedge clk); #1;
        @(negedge clk); #1;
        check_eq("reset.lane_valid", 32'(lane_valid_a), 32'b00);
        check_eq("reset.starve", 32'(starve_a), 32'b0);
        rst = 1'b0;

        // Basic dual issue: B and C ready, A not
        cycle_a(3'd3, 4'b0110, 2'b00, 1'b0, 4'b0110, "basic");
        check_eq("basic.lane_valid", 32'(lane_valid_a), 32'b11);
        check_eq("basic.lane0", 32'(lane_data_a[0]), 32'hB1);
        check_eq("basic.lane1", 32'(lane_data_a[1]), 32'hC2);

        // Back-pressure on lane0; lane1 drains at full rate
        do_reset();
        cycle_a(3'd2, 4'b0011, 2'b00, 1'b0, 4'b0011, "bp_fill");
        check_eq("bp_fill.lane0", 32'(lane_data_a[0]), 32'hA0);
        check_eq("bp_fill.lane1", 32'(lane_data_a[1]), 32'hB1);
        for (int k = 0; k < 4; k++) begin
            entries_a[0] = 8'(8'h10 + k);
            entries_a[1] = 8'(8'h20 + k);
            cycle_a(3'd2, 4'b0011, 2'b10, 1'b0, 4'b0001, "bp");
            check_eq("bp.lane_valid", 32'(lane_valid_a), 32'b11);
            check_eq("bp.lane0_stable", 32'(lane_data_a[0]), 32'hA0);
            check_eq("bp.lane1", 32'(lane_data_a[1]), 32'(8'h10 + k));
        end
        entries_a[0] = 8'hA0;
        entries_a[1] = 8'hB1;

        // Starvation: head never ready, younger ones keep bypassing
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            cycle_a(3'd4, 4'b1110, 2'b11, 1'b0, 4'b0110, "starve_bypass");
            check_eq("starve_bypass.starve", 32'(starve_a), 32'(c == 3));
        end
        for (int c = 0; c < 2; c++) begin
            cycle_a(3'd4, 4'b1110, 2'b11, 1'b0, 4'b0000, "starve_hold");
            check_eq("starve_hold.starve", 32'(starve_a), 32'b1);
            check_eq("starve_hold.lane_valid", 32'(lane_valid_a), 32'b00);
        end
        cycle_a(3'd4, 4'b1111, 2'b11, 1'b0, 4'b0001, "starve_release");
        check_eq("starve_release.starve", 32'(starve_a), 32'b0);
        check_eq("starve_release.lane_valid", 32'(lane_valid_a), 32'b01);
        check_eq("starve_release.lane0", 32'(lane_data_a[0]), 32'hA0);

        // Flush while in DRAIN with stalled lanes
        reach_drain();
        cycle_a(3'd4, 4'b0011, 2'b00, 1'b1, 4'b1111, "flush");
        check_eq("flush.lane_valid", 32'(lane_valid_a), 32'b00);
        check_eq("flush.starve", 32'(starve_a), 32'b0);
        // Age must restart from zero after the flush
        for (int c = 1; c <= 3; c++) begin
            cycle_a(3'd4, 4'b0000, 2'b00, 1'b0, 4'b0000, "post_flush");
            check_eq("post_flush.starve", 32'(starve_a), 32'(c == 3));
        end

        // Reset dominates flush
        reach_drain();
        rst = 1'b1;
        cycle_a(3'd4, 4'b1111, 2'b00, 1'b1, 4'b0000, "rst_prio");
        check_eq("rst_prio.lane_valid", 32'(lane_valid_a), 32'b00);
        check_eq("rst_prio.starve", 32'(starve_a), 32'b0);
        rst = 1'b0;

        // Boundaries: empty queue, single entry, full queue
        cycle_a(3'd0, 4'b1111, 2'b00, 1'b0, 4'b0000, "empty");
        check_eq("empty.lane_valid", 32'(lane_valid_a), 32'b00);
        cycle_a(3'd1, 4'b1111, 2'b00, 1'b0, 4'b0001, "size1");
        check_eq("size1.lane_valid", 32'(lane_valid_a), 32'b01);
        check_eq("size1.lane0", 32'(lane_data_a[0]), 32'hA0);
        cycle_a(3'd4, 4'b1111, 2'b11, 1'b0, 4'b0011, "full");
        check_eq("full.lane0", 32'(lane_data_a[0]), 32'hA0);
        check_eq("full.lane1", 32'(lane_data_a[1]), 32'hB1);

        // Random run on instance B against a queue + scheduler model
        do_reset();
        m_valid   = '0;
        m_drain   = 1'b0;
        m_age     = 0;
        next_id   = 0;
        transfers = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int l = 0; l < LanesB; l++) m_data[l] = 8'h00;

        for (int cyc = 0; cyc < 300; cyc++) begin
            if (mq.size() < SizeB && next_id < 250 && $urandom_range(0, 9) < 7) begin
                mq.push_back(data_t'(next_id));
                next_id++;
            end
            size_b = 4'(mq.size());
            for (int i = 0; i < SizeB; i++) entries_b[i] = (i < mq.size()) ? mq[i] : 8'h00;
            ready_b      = 8'($urandom());
            lane_ready_b = 3'($urandom());
            @(posedge clk);

            // Handshakes completing this cycle; each id must leave exactly once
            for (int l = 0; l < LanesB; l++) begin
                if (lane_valid_b[l] && lane_ready_b[l]) begin
                    check_eq("rnd.no_dup", 32'(seen[lane_data_b[l]]), 32'b0);
                    seen[lane_data_b[l]] = 1'b1;
                    transfers++;
                end
            end

            nfree = 0;
            for (int l = 0; l < LanesB; l++) begin
                if (!m_valid[l] || lane_ready_b[l]) begin
                    free_l[nfree] = l;
                    nfree++;
                end
            end
            valid_mask = '0;
            for (int i = 0; i < mq.size(); i++) valid_mask[i] = 1'b1;

            // Oldest ready entries go to the lowest free lanes, in order
            exp_pop = '0;
            fi      = 0;
            for (int l = 0; l < LanesB; l++) begin
                if (!m_valid[l] || lane_ready_b[l]) m_valid[l] = 1'b0;
            end
            for (int i = 0; i < mq.size(); i++) begin
                if (fi < nfree && ready_b[i] && (!m_drain || i == 0)) begin
                    exp_pop[i]          = 1'b1;
                    m_valid[free_l[fi]] = 1'b1;
                    m_data[free_l[fi]]  = mq[i];
                    fi++;
                end
            end
            check_eq("rnd.pop", 32'(pop_b), 32'(exp_pop));
            check_eq("rnd.pop_in_range", 32'(pop_b & ~valid_mask), 32'h0);
            check_eq("rnd.pop_le_free", 32'($countones(pop_b) <= nfree), 32'b1);

            old_age   = m_age;
            old_drain = m_drain;
            old_size  = mq.size();
            if (old_size == 0 || exp_pop[0]) m_age = 0;
            else if (m_age < TimeoutB) m_age++;
            if (!old_drain && old_age == TimeoutB - 1 && old_size > 0 && !exp_pop[0]) m_drain = 1'b1;
            else if (old_drain && exp_pop[0]) m_drain = 1'b0;

            new_q = {};
            for (int i = 0; i < mq.size(); i++) if (!exp_pop[i]) new_q.push_back(mq[i]);
            mq = new_q;

            @(negedge clk);
            #1;
            check_eq("rnd.lane_valid", 32'(lane_valid_b), 32'(m_valid));
            for (int l = 0; l < LanesB; l++) begin
                if (m_valid[l]) check_eq("rnd.lane_data", 32'(lane_data_b[l]), 32'(m_data[l]));
            end
            check_eq("rnd.starve", 32'(starve_b), 32'(m_drain));
        end
        check_eq("rnd.conserve", 32'(transfers + $countones(lane_valid_b) + mq.size()), 32'(next_id));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
